vga_timing_gen: RTL and testbench

- Produces the raster timing that every on-screen draw block consumes: `pixpulse`, `hcount`, `vcount`, `hsync`, `vsync` and `blank`.
- Default format is 640x480@60 Hz, with a 25 MHz pixel enable derived from the 100 MHz system clock.
- Sits between the board clock and the sprite, score and text renderers. Its outputs fan out to all of them and to the VGA pins.
- Also emits per-frame event pulses, so game logic can update state during vertical blanking.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/pix_en_div.sv | 33 +++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA raster constants: default 640x480@60 timing, count width and
// sync window bounds used by the timing generator and the on-screen renderers.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_CLK_DIV  = 4;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    // Sync pulses occupy [START, END) in pixel / line coordinates.
    localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pix_en_div.sv
// Pixel-enable divider: free-running 0..CLK_DIV-1 counter whose last state
// is the one-clock pixpulse. CLK_DIV must be at least 2.
module pix_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixpulse
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    // NOTE: non-blocking (<=) in clocked blocks so every flop samples the
    // pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pixpulse = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable, h/v counters, registered sync and
// blank, frame event pulses. Define VGA_FRAME_CNT_EN to build the frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             pixpulse,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             blank,
    output logic             frame_start,
    output logic             vblank_start,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST       = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST       = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_ACT_END    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_ACT_END    = cnt_t'(V_ACTIVE);
    localparam cnt_t H_SYNC_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t H_SYNC_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t V_SYNC_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t V_SYNC_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    cnt_t hcount_q, hcount_d;
    cnt_t vcount_q, vcount_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic blank_q, blank_d;

    pix_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .pixpulse (pixpulse)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (pixpulse) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        // Decoded from the next counts so the registered flags line up with
        // the registered counts on the same edge.
        hsync_d = !((hcount_d >= H_SYNC_START) && (hcount_d < H_SYNC_END));
        vsync_d = !((vcount_d >= V_SYNC_START) && (vcount_d < V_SYNC_END));
        blank_d = (hcount_d >= H_ACT_END) || (vcount_d >= V_ACT_END);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            blank_q  <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
        end
    end

    assign hcount       = hcount_q;
    assign vcount       = vcount_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign blank        = blank_q;
    assign frame_start  = pixpulse && (hcount_q == '0) && (vcount_q == '0);
    assign vblank_start = pixpulse && (hcount_q == '0) && (vcount_q == V_ACT_END);

`ifdef VGA_FRAME_CNT_EN
    logic       frame_wrap;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    assign frame_wrap = pixpulse && (hcount_q == H_LAST) && (vcount_q == V_LAST);

    always_comb begin
        frame_cnt_d = frame_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance, a CLK_DIV=2 instance of the
// same geometry and a tiny-raster instance, checked against a closed-form model.
module tb_vga_timing_gen;

    localparam int BD  = 2;
    localparam int BHA = 6;
    localparam int BHF = 1;
    localparam int BHS = 3;
    localparam int BHB = 2;
    localparam int BVA = 4;
    localparam int BVF = 1;
    localparam int BVS = 2;
    localparam int BVB = 1;
    localparam int BHT = BHA + BHF + BHS + BHB;
    localparam int BVT = BVA + BVF + BVS + BVB;
    localparam int B_FRAME_CLK = BHT * BVT * BD;

    typedef struct packed {
        logic       pix;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
        logic       vbs;
        logic [7:0] fc;
    } tv_t;

    localparam tv_t RST_VAL = '{pix: 1'b0, h: 10'd0, v: 10'd0, hs: 1'b1, vs: 1'b1,
                                bl: 1'b0, fs: 1'b0, vbs: 1'b0, fc: 8'd0};

`ifdef VGA_FRAME_CNT_EN
    localparam logic [7:0] FC_AFTER_257 = 8'd1;
`else
    localparam logic [7:0] FC_AFTER_257 = 8'd0;
`endif

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;

    logic       pix_a, hs_a, vs_a, bl_a, fs_a, vbs_a;
    logic [9:0] h_a, v_a;
    logic [7:0] fc_a;
    logic       pix_b, hs_b, vs_b, bl_b, fs_b, vbs_b;
    logic [9:0] h_b, v_b;
    logic [7:0] fc_b;
    logic       pix_c, hs_c, vs_c, bl_c, fs_c, vbs_c;
    logic [9:0] h_c, v_c;
    logic [7:0] fc_c;

    tv_t obs_a, obs_b, obs_c;
    longint ka, kb;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .pixpulse(pix_a), .hcount(h_a), .vcount(v_a),
        .hsync(hs_a), .vsync(vs_a), .blank(bl_a), .frame_start(fs_a),
        .vblank_start(vbs_a), .frame_cnt(fc_a)
    );

    vga_timing_gen #(.CLK_DIV(2)) u_dut_c (
        .clk(clk), .rst_n(rst_n_a), .pixpulse(pix_c), .hcount(h_c), .vcount(v_c),
        .hsync(hs_c), .vsync(vs_c), .blank(bl_c), .frame_start(fs_c),
        .vblank_start(vbs_c), .frame_cnt(fc_c)
    );

    vga_timing_gen #(
        .CLK_DIV(BD), .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .pixpulse(pix_b), .hcount(h_b), .vcount(v_b),
        .hsync(hs_b), .vsync(vs_b), .blank(bl_b), .frame_start(fs_b),
        .vblank_start(vbs_b), .frame_cnt(fc_b)
    );

    assign obs_a = {pix_a, h_a, v_a, hs_a, vs_a, bl_a, fs_a, vbs_a, fc_a};
    assign obs_b = {pix_b, h_b, v_b, hs_b, vs_b, bl_b, fs_b, vbs_b, fc_b};
    assign obs_c = {pix_c, h_c, v_c, hs_c, vs_c, bl_c, fs_c, vbs_c, fc_c};

    // Clock edges seen since reset release; the whole raster state follows from it.
    always @(posedge clk or negedge rst_n_a)
        if (!rst_n_a) ka <= 0;
        else          ka <= ka + 1;

    always @(posedge clk or negedge rst_n_b)
        if (!rst_n_b) kb <= 0;
        else          kb <= kb + 1;

    function automatic tv_t model(input longint k, input int d,
                                  input int ha, input int hf, input int hs, input int hb,
                                  input int va, input int vf, input int vs, input int vb);
        tv_t e;
        longint ht = longint'(ha + hf + hs + hb);
        longint vt = longint'(va + vf + vs + vb);
        longint n  = k / d;
        longint h  = n % ht;
        longint v  = (n / ht) % vt;
        e.pix = ((k % d) == longint'(d - 1));
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.hs  = !((h >= ha + hf) && (h < ha + hf + hs));
        e.vs  = !((v >= va + vf) && (v < va + vf + vs));
        e.bl  = (h >= ha) || (v >= va);
        e.fs  = e.pix && (h == 0) && (v == 0);
        e.vbs = e.pix && (h == 0) && (v == va);
`ifdef VGA_FRAME_CNT_EN
        e.fc  = 8'((n / (ht * vt)) % 256);
`else
        e.fc  = 8'd0;
`endif
        return e;
    endfunction

    function automatic tv_t expect_a();
        return model(ka, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic tv_t expect_c();
        return model(ka, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic tv_t expect_b();
        return model(kb, BD, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB);
    endfunction

    task automatic test_reset();
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (obs_a !== RST_VAL) begin
            n_fail++; $display("FAIL reset_a: got %h expected %h", obs_a, RST_VAL);
        end
        n_chk++;
        if (obs_b !== RST_VAL) begin
            n_fail++; $display("FAIL reset_b: got %h expected %h", obs_b, RST_VAL);
        end
        n_chk++;
        if (obs_c !== RST_VAL) begin
            n_fail++; $display("FAIL reset_c: got %h expected %h", obs_c, RST_VAL);
        end
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            if (cyc > 1) @(negedge clk);
            n_chk++;
            if (pix_a !== (cyc == 4)) begin
                n_fail++; $display("FAIL first_pixpulse cycle %0d: got %b expected %b", cyc, pix_a, cyc == 4);
            end
            n_chk++;
            if (obs_a !== expect_a()) begin
                n_fail++; $display("FAIL release_a cycle %0d: got %h expected %h", cyc, obs_a, expect_a());
            end
            n_chk++;
            if (obs_b !== expect_b()) begin
                n_fail++; $display("FAIL release_b cycle %0d: got %h expected %h", cyc, obs_b, expect_b());
            end
        end
        n_chk++;
        if ({h_a, v_a, fs_a} !== {10'd0, 10'd0, 1'b1}) begin
            n_fail++; $display("FAIL first_frame_start: got h=%0d v=%0d fs=%b expected h=0 v=0 fs=1", h_a, v_a, fs_a);
        end
    endtask

    task automatic test_line();
        longint k_l0_a = -1, k_l1_a = -1, k_l1_c = -1, k_l2_c = -1;
        int hs_low_a = 0, hs_low_c = 0, first_low_a = -1, first_low_c = -1;
        bit wrap_seen = 1'b0;
        logic prev_pix = 1'b0;
        logic [9:0] prev_h = 10'd0, prev_v = 10'd0;
        for (int i = 0; i < 3300; i++) begin
            n_chk++;
            if (obs_a !== expect_a()) begin
                n_fail++; $display("FAIL line_a k=%0d: got %h expected %h", ka, obs_a, expect_a());
            end
            n_chk++;
            if (obs_c !== expect_c()) begin
                n_fail++; $display("FAIL line_c k=%0d: got %h expected %h", ka, obs_c, expect_c());
            end
            if (pix_a && h_a == 0 && v_a == 0 && k_l0_a < 0) k_l0_a = ka;
            if (pix_a && h_a == 0 && v_a == 1 && k_l1_a < 0) k_l1_a = ka;
            if (pix_c && h_c == 0 && v_c == 1 && k_l1_c < 0) k_l1_c = ka;
            if (pix_c && h_c == 0 && v_c == 2 && k_l2_c < 0) k_l2_c = ka;
            if (v_a == 0 && !hs_a) begin
                if (first_low_a < 0) first_low_a = int'(h_a);
                hs_low_a++;
            end
            if (v_c == 0 && !hs_c) begin
                if (first_low_c < 0) first_low_c = int'(h_c);
                hs_low_c++;
            end
            if (prev_pix && prev_h == 10'd799 && prev_v == 10'd0 && h_a == 10'd0 && v_a == 10'd1)
                wrap_seen = 1'b1;
            prev_pix = pix_a;
            prev_h   = h_a;
            prev_v   = v_a;
            @(negedge clk);
        end
        n_chk++;
        if (!wrap_seen) begin
            n_fail++; $display("FAIL line_wrap: got no 799->0 / 0->1 step, expected one");
        end
        n_chk++;
        if (k_l1_a - k_l0_a !== 64'sd3200) begin
            n_fail++; $display("FAIL line_period_a: got %0d expected 3200", k_l1_a - k_l0_a);
        end
        n_chk++;
        if (k_l2_c - k_l1_c !== 64'sd1600) begin
            n_fail++; $display("FAIL line_period_c: got %0d expected 1600", k_l2_c - k_l1_c);
        end
        n_chk++;
        if (hs_low_a !== 384 || first_low_a !== 656) begin
            n_fail++; $display("FAIL hsync_a: got %0d clk from h=%0d expected 384 from 656", hs_low_a, first_low_a);
        end
        n_chk++;
        if (hs_low_c !== 192 || first_low_c !== 656) begin
            n_fail++; $display("FAIL hsync_c: got %0d clk from h=%0d expected 192 from 656", hs_low_c, first_low_c);
        end
    endtask

    task automatic test_frame();
        int fs_cnt = 0, vbs_cnt = 0, unblank = 0;
        longint k_fs0 = -1, k_fs1 = -1;
        logic [7:0] vs_mask = 8'd0;
        rst_n_b = 1'b0;
        @(negedge clk);
        rst_n_b = 1'b1;
        for (int i = 0; i < 2 * B_FRAME_CLK; i++) begin
            n_chk++;
            if (obs_b !== expect_b()) begin
                n_fail++; $display("FAIL frame_b k=%0d: got %h expected %h", kb, obs_b, expect_b());
            end
            if (fs_b) begin
                if (fs_cnt == 0) k_fs0 = kb; else k_fs1 = kb;
                fs_cnt++;
            end
            if (vbs_b) vbs_cnt++;
            if (!vs_b) vs_mask[v_b[2:0]] = 1'b1;
            if (!bl_b) unblank++;
            @(negedge clk);
        end
        n_chk++;
        if (fs_cnt !== 2 || k_fs1 - k_fs0 !== longint'(B_FRAME_CLK)) begin
            n_fail++; $display("FAIL frame_period: got %0d pulses %0d apart expected 2 pulses %0d apart",
                               fs_cnt, k_fs1 - k_fs0, B_FRAME_CLK);
        end
        n_chk++;
        if (vbs_cnt !== 2) begin
            n_fail++; $display("FAIL vblank_start_count: got %0d expected 2", vbs_cnt);
        end
        n_chk++;
        if (vs_mask !== 8'b0110_0000) begin
            n_fail++; $display("FAIL vsync_lines: got %b expected 01100000", vs_mask);
        end
        n_chk++;
        if (unblank !== 2 * BHA * BVA * BD) begin
            n_fail++; $display("FAIL active_area: got %0d expected %0d", unblank, 2 * BHA * BVA * BD);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5000 && h_a != 10'd300; i++) @(negedge clk);
        n_chk++;
        if (h_a !== 10'd300) begin
            n_fail++; $display("FAIL wait_h300: got %0d expected 300", h_a);
        end
        @(posedge clk);
        #2 rst_n_a = 1'b0;
        #1;
        n_chk++;
        if (obs_a !== RST_VAL) begin
            n_fail++; $display("FAIL async_reset_a: got %h expected %h", obs_a, RST_VAL);
        end
        n_chk++;
        if (obs_c !== RST_VAL) begin
            n_fail++; $display("FAIL async_reset_c: got %h expected %h", obs_c, RST_VAL);
        end
        repeat (2) @(negedge clk);
        rst_n_a = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            if (cyc > 1) @(negedge clk);
            n_chk++;
            if (obs_a !== expect_a()) begin
                n_fail++; $display("FAIL rerelease_a cycle %0d: got %h expected %h", cyc, obs_a, expect_a());
            end
        end
        n_chk++;
        if ({pix_a, h_a, v_a, fs_a} !== {1'b1, 10'd0, 10'd0, 1'b1}) begin
            n_fail++; $display("FAIL rerelease_frame_start: got pix=%b fs=%b expected 1 1", pix_a, fs_a);
        end

        repeat ($urandom_range(30, 170)) @(negedge clk);
        n_chk++;
        if (obs_b !== expect_b()) begin
            n_fail++; $display("FAIL pre_reset_b: got %h expected %h", obs_b, expect_b());
        end
        @(posedge clk);
        #3 rst_n_b = 1'b0;
        #1;
        n_chk++;
        if (obs_b !== RST_VAL) begin
            n_fail++; $display("FAIL async_reset_b: got %h expected %h", obs_b, RST_VAL);
        end
        repeat (3) @(negedge clk);
        rst_n_b = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({pix_b, h_b, v_b, fs_b} !== {1'b1, 10'd0, 10'd0, 1'b1}) begin
            n_fail++; $display("FAIL rerelease_b: got %h expected pix/fs at (0,0)", obs_b);
        end
    endtask

    task automatic test_random_spots();
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            n_chk++;
            if (obs_a !== expect_a()) begin
                n_fail++; $display("FAIL spot_a k=%0d: got %h expected %h", ka, obs_a, expect_a());
            end
            n_chk++;
            if (obs_b !== expect_b()) begin
                n_fail++; $display("FAIL spot_b k=%0d: got %h expected %h", kb, obs_b, expect_b());
            end
            n_chk++;
            if (obs_c !== expect_c()) begin
                n_fail++; $display("FAIL spot_c k=%0d: got %h expected %h", ka, obs_c, expect_c());
            end
        end
    endtask

    task automatic test_frame_cnt();
        longint target = longint'(257 * B_FRAME_CLK + 1);
        rst_n_b = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_b = 1'b1;
        for (int i = 0; i < 60000 && kb < target; i++) begin
            if (fs_b) begin
                n_chk++;
                if (obs_b !== expect_b()) begin
                    n_fail++; $display("FAIL frame_cnt_run k=%0d: got %h expected %h", kb, obs_b, expect_b());
                end
            end
            @(negedge clk);
        end
        n_chk++;
        if (kb !== target) begin
            n_fail++; $display("FAIL frame_cnt_timeout: got k=%0d expected %0d", kb, target);
        end
        n_chk++;
        if ({fs_b, fc_b} !== {1'b1, FC_AFTER_257}) begin
            n_fail++; $display("FAIL frame_cnt_wrap: got fs=%b cnt=%0d expected fs=1 cnt=%0d", fs_b, fc_b, FC_AFTER_257);
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_async_reset();
        test_random_spots();
        test_frame_cnt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
